// File: rtl/pueo_command_scheduler.sv
// pueo_command_scheduler
//   Emits one 32-bit command word per slot of SLOT_PERIOD clocks. The upper
//   half carries either a bit command (sync / pps / cmdproc_rst flags) or one
//   byte of the command-processor stream. Bit commands take priority over the
//   stream. The lower half carries the oldest queued trigger time, if any.
//
// Ports
//   sysclk_i, rst_i           clock, synchronous active-high reset
//   sync_req_i, pps_req_i,
//   cmdproc_rst_req_i         one-cycle bit-command requests (sticky until sent)
//   s_cmd_*                   AXI-stream style byte input, one beat per slot max
//   trig_time_i, trig_valid_i trigger push into a TRIG_DEPTH-entry FIFO
//   trig_overflow_o           sticky: a trigger was dropped on a full FIFO
//   command_o, command_valid_o command word and its one-cycle strobe
module pueo_command_scheduler #(
  parameter int SLOT_PERIOD = 8,
  parameter int TRIG_DEPTH  = 4
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        sync_req_i,
  input  logic        pps_req_i,
  input  logic        cmdproc_rst_req_i,
  input  logic [7:0]  s_cmd_tdata,
  input  logic [3:0]  s_cmd_tdest,
  input  logic        s_cmd_tlast,
  input  logic        s_cmd_tvalid,
  output logic        s_cmd_tready,
  input  logic [13:0] trig_time_i,
  input  logic        trig_valid_i,
  output logic        trig_overflow_o,
  output logic [31:0] command_o,
  output logic        command_valid_o
);

  localparam int CNT_W = $clog2(SLOT_PERIOD);
  localparam int PTR_W = $clog2(TRIG_DEPTH);

  logic [CNT_W-1:0] slot_cnt;
  logic             load;

  // Trigger FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [13:0]      trig_mem [TRIG_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             trig_pop;
  logic             trig_push;

  logic             pend_sync;
  logic             pend_pps;
  logic             pend_rst;
  logic [2:0]       bits_now;
  logic             bit_cmd;
  logic             beat;
  logic [15:0]      upper_nxt;
  logic [15:0]      lower_nxt;

  assign load       = (slot_cnt == CNT_W'(SLOT_PERIOD - 1));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Pop is decided from the FIFO state before this cycle's push, so a trigger
  // arriving in the load cycle waits for the next slot.
  assign trig_pop  = load && !fifo_empty;
  assign trig_push = trig_valid_i && (!fifo_full || trig_pop);

  // Same-cycle requests are folded in so a request landing on the load cycle
  // goes out now and its flag is not left set behind it.
  assign bits_now = {pend_rst | cmdproc_rst_req_i,
                     pend_pps | pps_req_i,
                     pend_sync | sync_req_i};
  assign bit_cmd  = |bits_now;

  assign s_cmd_tready = load && !bit_cmd && !rst_i;
  assign beat         = s_cmd_tvalid && s_cmd_tready;

  always_comb begin
    upper_nxt = 16'h0000;
    if (bit_cmd) begin
      upper_nxt = {4'b0000, 9'b0, bits_now};
    end else if (beat) begin
      upper_nxt = {(s_cmd_tlast ? 4'b0101 : 4'b0001), s_cmd_tdest, s_cmd_tdata};
    end
  end

  assign lower_nxt = trig_pop ? {2'b10, trig_mem[rd_ptr[PTR_W-1:0]]} : 16'h0000;

  // Slot timing, FIFO pointers, pending flags and the registered command word
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      slot_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pend_sync       <= 1'b0;
      pend_pps        <= 1'b0;
      pend_rst        <= 1'b0;
      trig_overflow_o <= 1'b0;
      command_o       <= 32'h0000_0000;
      command_valid_o <= 1'b0;
    end else begin
      slot_cnt        <= load ? '0 : slot_cnt + CNT_W'(1);
      command_valid_o <= load;
      if (load) begin
        command_o <= {upper_nxt, lower_nxt};
        pend_sync <= 1'b0;
        pend_pps  <= 1'b0;
        pend_rst  <= 1'b0;
      end else begin
        pend_sync <= bits_now[0];
        pend_pps  <= bits_now[1];
        pend_rst  <= bits_now[2];
      end
      if (trig_pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
      if (trig_push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end else if (trig_valid_i) begin
        trig_overflow_o <= 1'b1;
      end
    end
  end

  // Trigger storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge sysclk_i) begin
    if (trig_push) begin
      trig_mem[wr_ptr[PTR_W-1:0]] <= trig_time_i;
    end
  end

endmodule

// File: tb/tb_pueo_command_scheduler.sv
module tb_pueo_command_scheduler;
  localparam int P = 8;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        sync_req_i, pps_req_i, cmdproc_rst_req_i;
  logic [7:0]  s_cmd_tdata;
  logic [3:0]  s_cmd_tdest;
  logic        s_cmd_tlast, s_cmd_tvalid, s_cmd_tready;
  logic [13:0] trig_time_i;
  logic        trig_valid_i, trig_overflow_o;
  logic [31:0] command_o;
  logic        command_valid_o;

  always #5 clk = ~clk;

  pueo_command_scheduler #(.SLOT_PERIOD(P), .TRIG_DEPTH(D)) dut (
    .sysclk_i(clk), .rst_i(rst_i),
    .sync_req_i(sync_req_i), .pps_req_i(pps_req_i), .cmdproc_rst_req_i(cmdproc_rst_req_i),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tdest(s_cmd_tdest), .s_cmd_tlast(s_cmd_tlast),
    .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .trig_time_i(trig_time_i), .trig_valid_i(trig_valid_i), .trig_overflow_o(trig_overflow_o),
    .command_o(command_o), .command_valid_o(command_valid_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position within the slot, pending requests, queues of
  // outstanding triggers and stream bytes ({last, dest, data}).
  int          phase;
  bit          m_sync, m_pps, m_rst;
  logic [13:0] tq[$];
  logic [12:0] sq[$];
  logic [31:0] exp_cmd;
  logic        exp_valid;
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_stream();
    if (sq.size() > 0) begin
      s_cmd_tvalid = 1'b1;
      {s_cmd_tlast, s_cmd_tdest, s_cmd_tdata} = sq[0];
    end else begin
      s_cmd_tvalid = 1'b0;
      {s_cmd_tlast, s_cmd_tdest, s_cmd_tdata} = 13'h0;
    end
  endtask

  task automatic clear_pulses();
    sync_req_i = 0; pps_req_i = 0; cmdproc_rst_req_i = 0; trig_valid_i = 0;
  endtask

  // One clock: check tready before the edge, advance the model, check after.
  task automatic cyc();
    bit          load, rs, rp, rr, bt, tv, any;
    logic [13:0] tt;
    logic [12:0] w;
    logic [15:0] up, lo;
    drive_stream();
    #1;
    load = (phase == P - 1);
    rs = m_sync | sync_req_i;
    rp = m_pps | pps_req_i;
    rr = m_rst | cmdproc_rst_req_i;
    any = rs | rp | rr;
    chk("tready", {31'b0, s_cmd_tready}, {31'b0, load && !any});
    bt = s_cmd_tvalid && load && !any;
    tv = trig_valid_i;
    tt = trig_time_i;
    @(posedge clk);
    if (load) begin
      up = 16'h0;
      if (any) up = {13'b0, rr, rp, rs};
      else if (bt) begin
        w = sq.pop_front();
        up = {(w[12] ? 4'h5 : 4'h1), w[11:8], w[7:0]};
      end
      lo = 16'h0;
      if (tq.size() > 0) lo = {2'b10, tq.pop_front()};
      exp_cmd = {up, lo};
      exp_valid = 1'b1;
      m_sync = 0; m_pps = 0; m_rst = 0;
    end else begin
      exp_valid = 1'b0;
      m_sync = rs; m_pps = rp; m_rst = rr;
    end
    if (tv) begin
      if (tq.size() < D) tq.push_back(tt);
      else exp_ovf = 1'b1;
    end
    phase = (phase + 1) % P;
    #1;
    chk("valid", {31'b0, command_valid_o}, {31'b0, exp_valid});
    chk("command", command_o, exp_cmd);
    chk("overflow", {31'b0, trig_overflow_o}, {31'b0, exp_ovf});
    clear_pulses();
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      sync_req_i = 1'($urandom); pps_req_i = 1'($urandom);
      cmdproc_rst_req_i = 1'($urandom); trig_valid_i = 1'($urandom);
      trig_time_i = 14'($urandom);
      s_cmd_tvalid = 1'b1;
      #1;
      chk("rst_tready", {31'b0, s_cmd_tready}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_command", command_o, 32'd0);
      chk("rst_valid", {31'b0, command_valid_o}, 32'd0);
      chk("rst_overflow", {31'b0, trig_overflow_o}, 32'd0);
    end
    rst_i = 1'b0;
    clear_pulses();
    phase = 0; m_sync = 0; m_pps = 0; m_rst = 0;
    tq.delete(); sq.delete();
    exp_cmd = 32'h0; exp_valid = 1'b0; exp_ovf = 1'b0;
  endtask

  // Bounded: at most one slot of cycles.
  task automatic run_to_phase(input int ph);
    for (int i = 0; i < P && phase != ph; i++) cyc();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_pulses();
    trig_time_i = '0;
    s_cmd_tvalid = 0; s_cmd_tdata = '0; s_cmd_tdest = '0; s_cmd_tlast = 0;
    do_reset(3);

    // Idle: first strobe 8 cycles after reset, all-zero word
    repeat (P) cyc();
    chk("first_strobe", {31'b0, command_valid_o}, 32'd1);
    chk("idle_word", command_o, 32'h0000_0000);
    repeat (P) cyc();

    // Single trigger mid-slot
    run_to_phase(3);
    trig_valid_i = 1; trig_time_i = 14'h1234;
    cyc();
    run_to_phase(0);
    chk("trig_word", command_o, 32'h0000_9234);
    repeat (P) cyc();
    chk("trig_after", command_o, 32'h0000_0000);

    // sync + pps in one slot while a stream beat waits
    sq.push_back({1'b0, 4'd7, 8'h3C});
    run_to_phase(2); sync_req_i = 1; cyc();
    run_to_phase(5); pps_req_i = 1; cyc();
    run_to_phase(0);
    chk("bits_word", command_o, 32'h0003_0000);
    repeat (P) cyc();
    chk("deferred_beat", command_o, 32'h173C_0000);

    // Two-byte packet
    sq.push_back({1'b0, 4'd3, 8'hA5});
    sq.push_back({1'b1, 4'd3, 8'h5A});
    repeat (P) cyc();
    chk("pkt_byte0", command_o, 32'h13A5_0000);
    repeat (P) cyc();
    chk("pkt_byte1", command_o, 32'h535A_0000);

    // Request in the load cycle pre-empts a waiting beat
    sq.push_back({1'b1, 4'hF, 8'h11});
    run_to_phase(P - 1);
    cmdproc_rst_req_i = 1;
    cyc();
    chk("load_req", command_o, 32'h0004_0000);
    repeat (P) cyc();
    chk("beat_after_req", command_o, 32'h5F11_0000);
    repeat (P) cyc();
    chk("no_resend", command_o, 32'h0000_0000);

    // Five triggers in one slot, depth 4
    run_to_phase(1);
    for (int i = 1; i <= 5; i++) begin
      trig_valid_i = 1; trig_time_i = 14'(i);
      cyc();
    end
    for (int i = 1; i <= 4; i++) begin
      run_to_phase(0);
      chk("burst_trig", command_o, {16'h0, 2'b10, 14'(i)});
      cyc();
    end
    run_to_phase(0);
    chk("burst_dropped", command_o, 32'h0000_0000);
    chk("ovf_sticky", {31'b0, trig_overflow_o}, 32'd1);

    // Full FIFO with a push in the load cycle: push and pop both succeed
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      trig_valid_i = 1; trig_time_i = 14'(16'h100 + i);
      cyc();
    end
    run_to_phase(P - 1);
    trig_valid_i = 1; trig_time_i = 14'h3FFF;
    cyc();
    chk("full_pushpop_ovf", {31'b0, trig_overflow_o}, 32'd0);
    repeat (5 * P) cyc();

    // Reset mid-packet, then random traffic
    sq.push_back({1'b0, 4'd2, 8'h01});
    sq.push_back({1'b0, 4'd2, 8'h02});
    sq.push_back({1'b1, 4'd2, 8'h03});
    repeat (P + 3) cyc();
    do_reset(2);
    for (int i = 0; i < 800; i++) begin
      trig_valid_i = ($urandom % 4 == 0);
      trig_time_i = 14'($urandom);
      sync_req_i = ($urandom % 14 == 0);
      pps_req_i = ($urandom % 14 == 0);
      cmdproc_rst_req_i = ($urandom % 20 == 0);
      if (sq.size() < 3 && $urandom % 3 == 0)
        sq.push_back(13'($urandom));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
